// File: rtl/rs_alu.sv
// ---------------------------------------------------------------------------
// rs_alu : reservation station in front of the integer ALU.
//
// Buffers issued instructions whose source operands may still be waiting
// on ROB tags. Operands are captured from the common data bus (CDB), either
// at issue time (same-cycle bypass) or later by wakeup. Each cycle, the
// lowest-index entry whose operands are both ready is sent to the ALU
// output registers and its slot is freed.
//
// Ports
//   clk_in, rst_in        : clock (rising edge), async active-high reset
//   rdy_in                : global enable, low freezes every register
//   clear_in              : mispredict flush, drops all entries
//   issue_*               : instruction from the dispatcher
//   full                  : every entry is occupied (combinational)
//   cdb_valid/tag/value   : result broadcast
//   alu_*                 : registered ALU inputs, alu_valid marks a dispatch
// ---------------------------------------------------------------------------
module rs_alu #(
  parameter int unsigned RS_SIZE   = 8,
  parameter int unsigned OP_WIDTH  = 6,
  parameter int unsigned ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_in,

  input  logic                 issue_valid,
  input  logic [OP_WIDTH-1:0]  issue_op,
  input  logic [31:0]          issue_vj,
  input  logic [31:0]          issue_vk,
  input  logic [ROB_WIDTH-1:0] issue_qj,
  input  logic [ROB_WIDTH-1:0] issue_qk,
  input  logic                 issue_qj_pending,
  input  logic                 issue_qk_pending,
  input  logic [31:0]          issue_imm,
  input  logic [31:0]          issue_pc,
  input  logic [ROB_WIDTH-1:0] issue_dest,
  output logic                 full,

  input  logic                 cdb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_tag,
  input  logic [31:0]          cdb_value,

  output logic                 alu_valid,
  output logic [OP_WIDTH-1:0]  alu_op,
  output logic [31:0]          alu_rs1,
  output logic [31:0]          alu_rs2,
  output logic [31:0]          alu_pc,
  output logic [31:0]          alu_imm,
  output logic [ROB_WIDTH-1:0] alu_dest
);

  localparam int unsigned IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  // Entry storage. rj/rk flag an operand whose value is present in vj/vk;
  // while clear, qj/qk hold the producer tag being waited on.
  logic [RS_SIZE-1:0]   valid_q, valid_d;
  logic [RS_SIZE-1:0]   rj_q,    rj_d;
  logic [RS_SIZE-1:0]   rk_q,    rk_d;
  logic [OP_WIDTH-1:0]  op_q   [RS_SIZE];
  logic [OP_WIDTH-1:0]  op_d   [RS_SIZE];
  logic [31:0]          vj_q   [RS_SIZE];
  logic [31:0]          vj_d   [RS_SIZE];
  logic [31:0]          vk_q   [RS_SIZE];
  logic [31:0]          vk_d   [RS_SIZE];
  logic [ROB_WIDTH-1:0] qj_q   [RS_SIZE];
  logic [ROB_WIDTH-1:0] qj_d   [RS_SIZE];
  logic [ROB_WIDTH-1:0] qk_q   [RS_SIZE];
  logic [ROB_WIDTH-1:0] qk_d   [RS_SIZE];
  logic [31:0]          imm_q  [RS_SIZE];
  logic [31:0]          imm_d  [RS_SIZE];
  logic [31:0]          pc_q   [RS_SIZE];
  logic [31:0]          pc_d   [RS_SIZE];
  logic [ROB_WIDTH-1:0] dest_q [RS_SIZE];
  logic [ROB_WIDTH-1:0] dest_d [RS_SIZE];

  // ALU output registers
  logic                 alu_valid_q, alu_valid_d;
  logic [OP_WIDTH-1:0]  alu_op_q,    alu_op_d;
  logic [31:0]          alu_rs1_q,   alu_rs1_d;
  logic [31:0]          alu_rs2_q,   alu_rs2_d;
  logic [31:0]          alu_pc_q,    alu_pc_d;
  logic [31:0]          alu_imm_q,   alu_imm_d;
  logic [ROB_WIDTH-1:0] alu_dest_q,  alu_dest_d;

  // Selection / allocation results, both taken from the pre-edge state
  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic                 alloc_found;
  logic [IDX_W-1:0]     alloc_idx;

  // Same-cycle bypass of a broadcast onto the instruction being issued
  logic                 j_bypass;
  logic                 k_bypass;

  assign full = &valid_q;

  assign j_bypass = issue_qj_pending && cdb_valid && (cdb_tag == issue_qj);
  assign k_bypass = issue_qk_pending && cdb_valid && (cdb_tag == issue_qk);

  // Lowest-index priority pickers
  always_comb begin
    sel_found   = 1'b0;
    sel_idx     = '0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!sel_found && valid_q[i] && rj_q[i] && rk_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!alloc_found && !valid_q[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  // Next-state logic
  always_comb begin
    valid_d     = valid_q;
    rj_d        = rj_q;
    rk_d        = rk_q;
    op_d        = op_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    dest_d      = dest_q;
    alu_valid_d = alu_valid_q;
    alu_op_d    = alu_op_q;
    alu_rs1_d   = alu_rs1_q;
    alu_rs2_d   = alu_rs2_q;
    alu_pc_d    = alu_pc_q;
    alu_imm_d   = alu_imm_q;
    alu_dest_d  = alu_dest_q;

    if (rdy_in) begin
      if (clear_in) begin
        valid_d     = '0;
        alu_valid_d = 1'b0;
      end else begin
        // Wakeup: only occupied entries listen to the CDB
        if (cdb_valid) begin
          for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (valid_q[i] && !rj_q[i] && (qj_q[i] == cdb_tag)) begin
              vj_d[i] = cdb_value;
              rj_d[i] = 1'b1;
            end
            if (valid_q[i] && !rk_q[i] && (qk_q[i] == cdb_tag)) begin
              vk_d[i] = cdb_value;
              rk_d[i] = 1'b1;
            end
          end
        end

        // Dispatch; the ALU payload holds its previous value when idle
        alu_valid_d = sel_found;
        if (sel_found) begin
          alu_op_d         = op_q[sel_idx];
          alu_rs1_d        = vj_q[sel_idx];
          alu_rs2_d        = vk_q[sel_idx];
          alu_pc_d         = pc_q[sel_idx];
          alu_imm_d        = imm_q[sel_idx];
          alu_dest_d       = dest_q[sel_idx];
          valid_d[sel_idx] = 1'b0;
        end

        // Allocation targets a slot that was already free before this edge,
        // so it can never collide with the entry being dispatched or woken.
        if (issue_valid && !full && alloc_found) begin
          valid_d[alloc_idx] = 1'b1;
          op_d[alloc_idx]    = issue_op;
          imm_d[alloc_idx]   = issue_imm;
          pc_d[alloc_idx]    = issue_pc;
          dest_d[alloc_idx]  = issue_dest;
          qj_d[alloc_idx]    = issue_qj;
          qk_d[alloc_idx]    = issue_qk;

          if (j_bypass) begin
            vj_d[alloc_idx] = cdb_value;
            rj_d[alloc_idx] = 1'b1;
          end else begin
            vj_d[alloc_idx] = issue_vj;
            rj_d[alloc_idx] = !issue_qj_pending;
          end

          if (k_bypass) begin
            vk_d[alloc_idx] = cdb_value;
            rk_d[alloc_idx] = 1'b1;
          end else begin
            vk_d[alloc_idx] = issue_vk;
            rk_d[alloc_idx] = !issue_qk_pending;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q     <= '0;
      rj_q        <= '0;
      rk_q        <= '0;
      op_q        <= '{default: '0};
      vj_q        <= '{default: '0};
      vk_q        <= '{default: '0};
      qj_q        <= '{default: '0};
      qk_q        <= '{default: '0};
      imm_q       <= '{default: '0};
      pc_q        <= '{default: '0};
      dest_q      <= '{default: '0};
      alu_valid_q <= 1'b0;
      alu_op_q    <= '0;
      alu_rs1_q   <= '0;
      alu_rs2_q   <= '0;
      alu_pc_q    <= '0;
      alu_imm_q   <= '0;
      alu_dest_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      rj_q        <= rj_d;
      rk_q        <= rk_d;
      op_q        <= op_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      dest_q      <= dest_d;
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      alu_rs1_q   <= alu_rs1_d;
      alu_rs2_q   <= alu_rs2_d;
      alu_pc_q    <= alu_pc_d;
      alu_imm_q   <= alu_imm_d;
      alu_dest_q  <= alu_dest_d;
    end
  end

  assign alu_valid = alu_valid_q;
  assign alu_op    = alu_op_q;
  assign alu_rs1   = alu_rs1_q;
  assign alu_rs2   = alu_rs2_q;
  assign alu_pc    = alu_pc_q;
  assign alu_imm   = alu_imm_q;
  assign alu_dest  = alu_dest_q;

endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- Reservation station feeding the integer ALU. It buffers issued instructions whose source operands may still be pending ROB tags.
- It captures operand values from the common data bus (CDB) and sends one operand-ready instruction per cycle to the ALU as op/rs1/rs2/PC/imm plus destination tag.
- It sits between the dispatcher and the ALU. The ALU result returns to it via the CDB.

Parameters:
- RS_SIZE, 8, number of entries (power of 2, ≥2).
- OP_WIDTH, 6, width of the op enum.
- ROB_WIDTH, 4, ROB tag width.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  global enable; low = stall.
- clear_in  input  1  flush on mispredict.
- issue_valid  input  1  dispatcher presents an instruction.
- issue_op  input  OP_WIDTH  operation.
- issue_vj, issue_vk  input  32  operand values, used when the matching q_pending is 0.
- issue_qj, issue_qk  input  ROB_WIDTH  producer tags.
- issue_qj_pending, issue_qk_pending  input  1  operand awaits its producer tag.
- issue_imm  input  32  immediate.
- issue_pc  input  32  instruction PC.
- issue_dest  input  ROB_WIDTH  destination ROB tag.
- full  output  1  no free entry.
- cdb_valid  input  1  result broadcast valid.
- cdb_tag  input  ROB_WIDTH  broadcast tag.
- cdb_value  input  32  broadcast value.
- alu_valid  output  1  ALU inputs valid this cycle.
- alu_op  output  OP_WIDTH.
- alu_rs1, alu_rs2  output  32.
- alu_pc  output  32.
- alu_imm  output  32.
- alu_dest  output  ROB_WIDTH.

Behaviour:

Reset
- rst_in high (async): all entries invalid.
- alu_valid = 0; alu_op, alu_rs1, alu_rs2, alu_pc, alu_imm, alu_dest all 0.
- full = 0 once reset is applied.

Priority and stall
- Order: rst_in > !rdy_in > clear_in > normal operation.
- rdy_in low: every register, including the alu_* outputs, holds its value. issue_valid and cdb_valid are ignored.

Flush
- clear_in high (with rdy_in high): next edge invalidates all entries and sets alu_valid = 0.
- An issue presented in the same cycle is dropped.

Full
- full is combinational from the current valid vector: 1 when all RS_SIZE entries are valid.
- Issue while full is dropped; stored entries are not corrupted.

Allocation
- issue_valid && !full: write the instruction into the lowest-index invalid entry, evaluated on the pre-edge valid vector.
- A slot freed by this cycle's selection is not reused in the same cycle.

Operand capture at issue
- For each operand: if pending, cdb_valid, and cdb_tag equals the issue tag, store cdb_value and mark the operand ready (same-cycle bypass).
- Otherwise, if pending, store the tag and mark the operand waiting.
- Otherwise, store the value and mark the operand ready.

Wakeup
- Each valid entry with a waiting operand whose tag equals cdb_tag while cdb_valid captures cdb_value at the edge.
- Both operands of one entry may wake on the same broadcast.

Selection
- Each edge: choose the lowest-index valid entry whose both operands are ready in the pre-edge state.
- Drive that entry's fields to the alu_* registers, set alu_valid = 1, and invalidate the entry.
- If no entry is ready: alu_valid = 0; other alu_* outputs hold their old values.

Latency
- An issued instruction with ready operands reaches the ALU at the edge after the issue edge (1 cycle).
- An entry woken at edge N is dispatched no earlier than edge N+1.

Width rules
- No arithmetic is performed; values pass unchanged.
- Tag compare is an exact ROB_WIDTH equality.

Test Plan:
1. Reset mid-operation: with 3 valid entries, assert rst_in between edges → alu_valid = 0 and full = 0 immediately; no dispatch after release until a new issue arrives.
2. Ready issue: issue ADD with vj = 5, vk = 7, dest = 3, both operands not pending → next cycle alu_valid = 1, alu_rs1 = 5, alu_rs2 = 7, alu_dest = 3; following cycle alu_valid = 0.
3. Wakeup: issue ADDI with qj = 2 pending, imm = 0x10, pc = 0x100. Hold ≥2 cycles with alu_valid = 0, then broadcast cdb tag 2, value 0x20 → alu_valid = 1 one cycle after the broadcast, with alu_rs1 = 0x20, alu_imm = 0x10, alu_pc = 0x100.
4. Bypass: issue with qj = qk = 6 pending while cdb_valid is high with tag 6, value 9 in the same cycle → dispatched next cycle with alu_rs1 = alu_rs2 = 9.
5. Full and order: issue 8 entries all waiting on tag 1 → full = 1 and a 9th issue is dropped. Broadcast tag 1 → dispatches appear on 8 consecutive cycles in entry-index order, and full drops the cycle after the first dispatch.
6. Stall and flush: with rdy_in low for 3 cycles during a CDB broadcast → no capture and outputs held. Then clear_in with issue_valid in the same cycle → next cycle all entries invalid, alu_valid = 0, full = 0, and no later dispatch occurs.
